ks_pluck_scheduler: RTL and testbench
=====================================

Name: ks_pluck_scheduler

Overview:
Shares one Karplus-Strong string voice between NUM_REQ note requesters. It uses round-robin arbitration with valid/ready handshakes and validates each requested period. It drives the string's pluck, period, drum/string select and freeze controls. Each requested period is held stable for the whole noise burst, and a re-pluck is allowed only after a programmable minimum sustain.

Parameters:
NUM_REQ, 4, number of requesters
DATA_WIDTH, 8, width of period and sample fields
MAX_LENGTH, 64, string delay-line length; legal period range is 2..MAX_LENGTH-1
HOLD_WIDTH, 16, width of the minimum-sustain counter
ID_WIDTH, $clog2(NUM_REQ), requester index width

Ports:
clk_i  in  1  clock
rst_n  in  1  synchronous, active-low reset
req_valid_i  in  NUM_REQ  per-requester note request
req_period_i  in  NUM_REQ*DATA_WIDTH  packed periods; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
req_drum_i  in  NUM_REQ  1 = drum mode for that request
req_ready_o  out  NUM_REQ  one-hot grant, combinational, at most one bit set
min_hold_i  in  HOLD_WIDTH  minimum SUSTAIN cycles before a new grant
mute_i  in  1  block grants and freeze the string
err_clr_i  in  1  clears err_period_o
pluck_o  out  1  pluck strobe to the string
period_o  out  DATA_WIDTH  period to the string
drum_string_no  out  1  drum/string select
freeze_o  out  1  wavetable freeze
busy_o  out  1  high in PLUCK or BURST
active_id_o  out  ID_WIDTH  index of the last granted requester
err_period_o  out  1  sticky flag: an illegal period was rejected

Behaviour:
- Reset values: FSM=IDLE, pluck_o=0, period_o=MAX_LENGTH-1, drum_string_no=0, freeze_o=0, busy_o=0, active_id_o=0, err_period_o=0, RR pointer=0, burst_cnt=0, hold_cnt=0.
- Reset applied mid-operation aborts any state; the reset values appear on the next edge.
- States: IDLE, PLUCK, BURST, SUSTAIN.
- Arbitration window: state is IDLE, or state is SUSTAIN with hold_cnt>=min_hold_i.
  - Inside the window with mute_i=0 and any valid: the winner is the first valid requester at or after the RR pointer, wrapping.
  - req_ready_o[winner]=1 in that same cycle; the pointer becomes winner+1 mod NUM_REQ.
  - Outside the window, or with mute_i=1, req_ready_o=0.
- Legal grant (2<=period<=MAX_LENGTH-1) at cycle T:
  - period_o, drum_string_no and active_id_o are registered at the T edge.
  - T+1: PLUCK, pluck_o=1 for exactly one cycle.
  - T+2 .. T+2+period: BURST, lasting period+1 cycles; burst_cnt counts 0..period.
  - T+period+3: SUSTAIN; hold_cnt=0 on entry, then increments and saturates at all-ones.
- Illegal period: the grant handshake still completes and the pointer still advances. err_period_o is set, the state is unchanged, and period_o is not updated.
- period_o and drum_string_no are stable from the grant until the next legal grant; they never change during PLUCK or BURST.
- pluck_o is low for at least period+1 cycles between strobes, so every strobe is a clean rising edge.
- Requests arriving during PLUCK or BURST wait; requesters hold valid until they see ready.
- min_hold_i=0: a grant can occur in the first SUSTAIN cycle, giving back-to-back spacing of period+3 cycles.
- min_hold_i is sampled live; a change takes effect on the comparison immediately.
- SUSTAIN lasts until a grant; there is no timeout back to IDLE.
- freeze_o is mute_i registered, one cycle latency.
- mute_i does not abort a PLUCK or BURST already in progress.
- err_period_o: err_clr_i clears it unless a new illegal grant occurs in the same cycle, in which case set wins.
- busy_o is registered and equals (next state is PLUCK or BURST).

Decomposition:
- Package ks_pkg:
  - FSM state enum {IDLE, PLUCK, BURST, SUSTAIN}.
  - Constants KS_MIN_PERIOD=2 and KS_MAX_PERIOD(MAX_LENGTH)=MAX_LENGTH-1.
- Sub-module ks_rr_arbiter (NUM_REQ): combinational one-hot grant from a valid vector and a pointer.
  - Outputs the winner index and an any_valid flag.
  - The pointer register stays in the scheduler.

Test Plan:
1. After reset, req_valid_i[0]=1, period 10, min_hold 0 → req_ready_o[0]=1 in the same cycle; pluck_o high exactly at T+1; busy_o high for 12 cycles; period_o=10 throughout; SUSTAIN entered at T+13.
2. Requesters 0, 1 and 2 all valid, each period 5, min_hold 0 → grant order 0, 1, 2; consecutive pluck_o pulses are 8 cycles apart; active_id_o=0, 1, 2 in turn.
3. Requester 1 with period 1, then period 64 → each is granted with no pluck_o, period_o unchanged, err_period_o=1 until err_clr_i; with set and clear in the same cycle, the flag stays 1.
4. min_hold 20, requester 3 valid during BURST → no ready until SUSTAIN entry+20, then req_ready_o[3]=1 and a pluck one cycle later.
5. mute_i=1 in IDLE with requester 0 valid → no grant; freeze_o=1 one cycle after mute; release mute → grant that cycle, freeze_o=0 the next cycle.
6. rst_n=0 mid-BURST → next edge: pluck_o=0, busy_o=0, period_o=63, pointer 0; the first request afterwards goes to requester 0.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared types and constants for the Karplus-Strong pluck scheduler.
// Holds the FSM state encoding and the legal period bounds.
package ks_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLUCK   = 2'd1,
    BURST   = 2'd2,
    SUSTAIN = 2'd3
  } ks_state_e;

  localparam int KS_MIN_PERIOD = 2;

  function automatic int KS_MAX_PERIOD(input int max_length);
    return max_length - 1;
  endfunction

endpackage

// File: rtl/ks_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, wrapping.
// The pointer itself is owned by the caller.
module ks_rr_arbiter
  import ks_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] winner_o,
  output logic                any_valid_o
);

  int w_idx;

  // Scan from the farthest offset down so the nearest valid requester is written last.
  always_comb begin
    grant_o     = '0;
    winner_o    = '0;
    w_idx       = 0;
    any_valid_o = |valid_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx    = (int'(ptr_i) + i) % NUM_REQ;
      winner_o = valid_i[w_idx] ? ID_WIDTH'(w_idx) : winner_o;
    end
    grant_o[winner_o] = any_valid_o;
  end

endmodule

// File: rtl/ks_pluck_scheduler.sv
// Shares one Karplus-Strong voice between NUM_REQ requesters: round-robin grant,
// period validation, pluck/burst/sustain sequencing with a minimum sustain time.
module ks_pluck_scheduler
  import ks_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LENGTH = 64,
  parameter int HOLD_WIDTH = 16,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_period_i,
  input  logic [NUM_REQ-1:0]            req_drum_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [HOLD_WIDTH-1:0]         min_hold_i,
  input  logic                          mute_i,
  input  logic                          err_clr_i,
  output logic                          pluck_o,
  output logic [DATA_WIDTH-1:0]         period_o,
  output logic                          drum_string_no,
  output logic                          freeze_o,
  output logic                          busy_o,
  output logic [ID_WIDTH-1:0]           active_id_o,
  output logic                          err_period_o
);

  localparam logic [DATA_WIDTH-1:0] L_MIN_P = DATA_WIDTH'(KS_MIN_PERIOD);
  localparam logic [DATA_WIDTH-1:0] L_MAX_P = DATA_WIDTH'(KS_MAX_PERIOD(MAX_LENGTH));

  ks_state_e               r_state;
  ks_state_e               w_next_state;
  logic [ID_WIDTH-1:0]     r_ptr;
  logic [DATA_WIDTH-1:0]   r_burst_cnt;
  logic [HOLD_WIDTH-1:0]   r_hold_cnt;
  logic                    r_pluck;
  logic [DATA_WIDTH-1:0]   r_period;
  logic                    r_drum;
  logic                    r_freeze;
  logic                    r_busy;
  logic [ID_WIDTH-1:0]     r_active_id;
  logic                    r_err;

  logic [NUM_REQ-1:0]      w_grant_vec;
  logic [ID_WIDTH-1:0]     w_winner;
  logic                    w_any_valid;
  logic                    w_window;
  logic                    w_fire;
  logic                    w_legal;
  logic [DATA_WIDTH-1:0]   w_sel_period;

  ks_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .valid_i     (req_valid_i),
    .ptr_i       (r_ptr),
    .grant_o     (w_grant_vec),
    .winner_o    (w_winner),
    .any_valid_o (w_any_valid)
  );

  // Next-state, arbitration window and the combinational ready handshake.
  always_comb begin
    w_next_state = r_state;
    w_window     = 1'b0;
    case (r_state)
      IDLE:    w_window = 1'b1;
      PLUCK:   w_next_state = BURST;
      BURST:   w_next_state = (r_burst_cnt == r_period) ? SUSTAIN : BURST;
      SUSTAIN: w_window = (r_hold_cnt >= min_hold_i);
      default: w_next_state = IDLE;
    endcase
    w_fire       = w_window && !mute_i && w_any_valid;
    w_sel_period = req_period_i[w_winner*DATA_WIDTH +: DATA_WIDTH];
    w_legal      = (w_sel_period >= L_MIN_P) && (w_sel_period <= L_MAX_P);
    // An illegal period completes the handshake but leaves the voice untouched.
    if (w_fire && w_legal) begin
      w_next_state = PLUCK;
    end else begin
      w_next_state = w_next_state;
    end
    req_ready_o = w_fire ? w_grant_vec : '0;
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered outputs, counters and the round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_burst_cnt <= '0;
      r_hold_cnt  <= '0;
      r_pluck     <= 1'b0;
      r_period    <= L_MAX_P;
      r_drum      <= 1'b0;
      r_freeze    <= 1'b0;
      r_busy      <= 1'b0;
      r_active_id <= '0;
      r_err       <= 1'b0;
    end else begin
      r_pluck     <= (w_next_state == PLUCK);
      r_busy      <= (w_next_state == PLUCK) || (w_next_state == BURST);
      r_freeze    <= mute_i;
      r_burst_cnt <= (r_state == BURST) ? r_burst_cnt + 1'b1 : '0;
      if (r_state == SUSTAIN && w_next_state == SUSTAIN) begin
        r_hold_cnt <= (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
      if (w_fire) begin
        r_ptr <= (w_winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
      if (w_fire && w_legal) begin
        r_period    <= w_sel_period;
        r_drum      <= req_drum_i[w_winner];
        r_active_id <= w_winner;
      end
      if (w_fire && !w_legal) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  assign pluck_o        = r_pluck;
  assign period_o       = r_period;
  assign drum_string_no = r_drum;
  assign freeze_o       = r_freeze;
  assign busy_o         = r_busy;
  assign active_id_o    = r_active_id;
  assign err_period_o   = r_err;

endmodule

// File: tb/tb_ks_pluck_scheduler.sv
// Self-checking bench for ks_pluck_scheduler: directed scenarios plus a randomized
// run against a timeline-based reference model (grant time + period arithmetic).
module tb_ks_pluck_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid_i = 4'b0;
  logic [31:0] req_period_i = 32'b0;
  logic [3:0]  req_drum_i = 4'b0;
  logic [3:0]  req_ready_o;
  logic [15:0] min_hold_i = 16'd0;
  logic        mute_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic        pluck_o;
  logic [7:0]  period_o;
  logic        drum_string_no;
  logic        freeze_o;
  logic        busy_o;
  logic [1:0]  active_id_o;
  logic        err_period_o;

  int n_checks = 0;
  int n_errors = 0;

  ks_pluck_scheduler dut (
    .clk_i(clk_i), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_period_i(req_period_i),
    .req_drum_i(req_drum_i), .req_ready_o(req_ready_o), .min_hold_i(min_hold_i),
    .mute_i(mute_i), .err_clr_i(err_clr_i), .pluck_o(pluck_o), .period_o(period_o),
    .drum_string_no(drum_string_no), .freeze_o(freeze_o), .busy_o(busy_o),
    .active_id_o(active_id_o), .err_period_o(err_period_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input int per, input logic drum);
    req_period_i[k*8 +: 8] = 8'(per);
    req_drum_i[k] = drum;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid_i = 4'b0; req_period_i = 32'b0; req_drum_i = 4'b0;
    mute_i = 1'b0; err_clr_i = 1'b0; min_hold_i = 16'd0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (pluck_o !== 1'b0) begin n_errors++; $display("FAIL rst_pluck: got %0h want 0", pluck_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %0h want 0", busy_o); end
    n_checks++; if (period_o !== 8'd63) begin n_errors++; $display("FAIL rst_period: got %0d want 63", period_o); end
    n_checks++; if (drum_string_no !== 1'b0) begin n_errors++; $display("FAIL rst_drum: got %0h want 0", drum_string_no); end
    n_checks++; if (freeze_o !== 1'b0) begin n_errors++; $display("FAIL rst_freeze: got %0h want 0", freeze_o); end
    n_checks++; if (active_id_o !== 2'd0) begin n_errors++; $display("FAIL rst_active: got %0d want 0", active_id_o); end
    n_checks++; if (err_period_o !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %0h want 0", err_period_o); end
    n_checks++; if (req_ready_o !== 4'b0) begin n_errors++; $display("FAIL rst_ready: got %b want 0000", req_ready_o); end
  endtask

  task automatic test_single_pluck();
    do_reset();
    set_req(0, 10, 1'b0); req_valid_i = 4'b0001; #1;
    n_checks++; if (req_ready_o !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b want 0001", req_ready_o); end
    for (int i = 1; i <= 13; i++) begin
      cyc();
      req_valid_i = 4'b0000;
      if (i >= 12) begin set_req(1, 5, 1'b0); req_valid_i = 4'b0010; end
      #1;
      n_checks++; if (pluck_o !== (i == 1)) begin n_errors++; $display("FAIL single_pluck c%0d: got %0h want %0h", i, pluck_o, (i == 1)); end
      n_checks++; if (busy_o !== (i <= 12)) begin n_errors++; $display("FAIL single_busy c%0d: got %0h want %0h", i, busy_o, (i <= 12)); end
      n_checks++; if (period_o !== 8'd10) begin n_errors++; $display("FAIL single_period c%0d: got %0d want 10", i, period_o); end
      if (i >= 12) begin
        n_checks++;
        if (req_ready_o !== ((i == 13) ? 4'b0010 : 4'b0000)) begin
          n_errors++; $display("FAIL single_sustain_entry c%0d: got %b", i, req_ready_o);
        end
      end
    end
    cyc(); req_valid_i = 4'b0;
  endtask

  task automatic test_round_robin();
    int gid[3]; int pcyc[3]; int pact[3]; int gcnt; int pcnt; logic [3:0] pend;
    do_reset();
    for (int k = 0; k < 3; k++) begin set_req(k, 5, 1'b0); gid[k] = -1; pcyc[k] = -100; pact[k] = -1; end
    pend = 4'b0111; gcnt = 0; pcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) cyc();
      req_valid_i = pend; #1;
      if (pluck_o === 1'b1 && pcnt < 3) begin pcyc[pcnt] = c; pact[pcnt] = int'(active_id_o); pcnt++; end
      if (req_ready_o !== 4'b0 && gcnt < 3) begin
        for (int k = 0; k < 4; k++) if (req_ready_o[k]) begin gid[gcnt] = k; pend[k] = 1'b0; end
        gcnt++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (gid[i] != i) begin n_errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, gid[i], i); end
      n_checks++; if (pact[i] != i) begin n_errors++; $display("FAIL rr_active[%0d]: got %0d want %0d", i, pact[i], i); end
      if (i > 0) begin
        n_checks++;
        if (pcyc[i] - pcyc[i-1] != 8) begin n_errors++; $display("FAIL rr_spacing[%0d]: got %0d want 8", i, pcyc[i] - pcyc[i-1]); end
      end
    end
    req_valid_i = 4'b0;
  endtask

  task automatic test_illegal_period();
    do_reset();
    set_req(0, 7, 1'b0); req_valid_i = 4'b0001;
    cyc(); req_valid_i = 4'b0;
    repeat (9) cyc();
    set_req(1, 1, 1'b0); req_valid_i = 4'b0010; #1;
    n_checks++; if (req_ready_o !== 4'b0010) begin n_errors++; $display("FAIL ill_ready1: got %b want 0010", req_ready_o); end
    cyc(); set_req(1, 64, 1'b0); #1;
    n_checks++; if (req_ready_o !== 4'b0010) begin n_errors++; $display("FAIL ill_ready2: got %b want 0010", req_ready_o); end
    n_checks++; if (err_period_o !== 1'b1) begin n_errors++; $display("FAIL ill_err1: got %0h want 1", err_period_o); end
    n_checks++; if (pluck_o !== 1'b0) begin n_errors++; $display("FAIL ill_pluck1: got %0h want 0", pluck_o); end
    cyc(); req_valid_i = 4'b0; err_clr_i = 1'b1; #1;
    n_checks++; if (err_period_o !== 1'b1) begin n_errors++; $display("FAIL ill_err2: got %0h want 1", err_period_o); end
    n_checks++; if (pluck_o !== 1'b0 || busy_o !== 1'b0) begin n_errors++; $display("FAIL ill_idle: pluck %0h busy %0h want 0 0", pluck_o, busy_o); end
    n_checks++; if (period_o !== 8'd7) begin n_errors++; $display("FAIL ill_period: got %0d want 7", period_o); end
    cyc(); set_req(1, 1, 1'b0); req_valid_i = 4'b0010; #1;
    n_checks++; if (err_period_o !== 1'b0) begin n_errors++; $display("FAIL ill_clr: got %0h want 0", err_period_o); end
    n_checks++; if (req_ready_o !== 4'b0010) begin n_errors++; $display("FAIL ill_ready3: got %b want 0010", req_ready_o); end
    cyc(); req_valid_i = 4'b0; err_clr_i = 1'b0; #1;
    n_checks++; if (err_period_o !== 1'b1) begin n_errors++; $display("FAIL ill_set_wins: got %0h want 1", err_period_o); end
    n_checks++; if (period_o !== 8'd7) begin n_errors++; $display("FAIL ill_period2: got %0d want 7", period_o); end
  endtask

  task automatic test_min_hold();
    do_reset();
    min_hold_i = 16'd20;
    set_req(0, 4, 1'b0); req_valid_i = 4'b0001;
    for (int c = 1; c <= 28; c++) begin
      cyc();
      req_valid_i = 4'b0;
      if (c >= 3 && c <= 27) begin set_req(3, 9, 1'b1); req_valid_i = 4'b1000; end
      #1;
      if (c >= 3 && c <= 27) begin
        n_checks++;
        if (req_ready_o !== ((c == 27) ? 4'b1000 : 4'b0000)) begin
          n_errors++; $display("FAIL hold_ready c%0d: got %b", c, req_ready_o);
        end
      end
    end
    n_checks++; if (pluck_o !== 1'b1) begin n_errors++; $display("FAIL hold_pluck: got %0h want 1", pluck_o); end
    n_checks++; if (period_o !== 8'd9) begin n_errors++; $display("FAIL hold_period: got %0d want 9", period_o); end
    n_checks++; if (active_id_o !== 2'd3) begin n_errors++; $display("FAIL hold_active: got %0d want 3", active_id_o); end
  endtask

  task automatic test_mute();
    do_reset();
    mute_i = 1'b1; set_req(0, 6, 1'b0); req_valid_i = 4'b0001; #1;
    n_checks++; if (req_ready_o !== 4'b0) begin n_errors++; $display("FAIL mute_ready0: got %b want 0000", req_ready_o); end
    cyc(); #1;
    n_checks++; if (req_ready_o !== 4'b0) begin n_errors++; $display("FAIL mute_ready1: got %b want 0000", req_ready_o); end
    n_checks++; if (freeze_o !== 1'b1) begin n_errors++; $display("FAIL mute_freeze: got %0h want 1", freeze_o); end
    cyc(); mute_i = 1'b0; #1;
    n_checks++; if (req_ready_o !== 4'b0001) begin n_errors++; $display("FAIL mute_release: got %b want 0001", req_ready_o); end
    cyc(); req_valid_i = 4'b0; #1;
    n_checks++; if (freeze_o !== 1'b0) begin n_errors++; $display("FAIL unfreeze: got %0h want 0", freeze_o); end
    n_checks++; if (pluck_o !== 1'b1) begin n_errors++; $display("FAIL mute_pluck: got %0h want 1", pluck_o); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 20, 1'b1); req_valid_i = 4'b0001;
    cyc(); req_valid_i = 4'b0;
    repeat (4) cyc();
    for (int k = 0; k < 4; k++) set_req(k, 5, 1'b0);
    rst_n = 1'b0; req_valid_i = 4'b1111; #1;
    n_checks++; if (req_ready_o !== 4'b0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL mid_burst: ready %b busy %0h want 0000 1", req_ready_o, busy_o); end
    cyc(); rst_n = 1'b1; #1;
    n_checks++; if (pluck_o !== 1'b0 || busy_o !== 1'b0) begin n_errors++; $display("FAIL mid_rst_ctl: pluck %0h busy %0h want 0 0", pluck_o, busy_o); end
    n_checks++; if (period_o !== 8'd63) begin n_errors++; $display("FAIL mid_rst_period: got %0d want 63", period_o); end
    n_checks++; if (drum_string_no !== 1'b0) begin n_errors++; $display("FAIL mid_rst_drum: got %0h want 0", drum_string_no); end
    n_checks++; if (req_ready_o !== 4'b0001) begin n_errors++; $display("FAIL mid_rst_ptr: got %b want 0001", req_ready_o); end
    cyc(); req_valid_i = 4'b0;
  endtask

  task automatic test_random();
    int g, p, ptr, w, age, r;
    int pper[4];
    logic [3:0] pend, pdrum, e_ready;
    logic [7:0] e_period;
    logic [1:0] e_active;
    logic e_drum, e_err, e_freeze, e_busy, e_pluck, win, legal;
    do_reset();
    g = -1; p = 0; ptr = 0; pend = 4'b0; pdrum = 4'b0;
    e_period = 8'd63; e_active = 2'd0; e_drum = 1'b0; e_err = 1'b0; e_freeze = 1'b0;
    for (int k = 0; k < 4; k++) pper[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) cyc();
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          r = int'($urandom_range(0, 11));
          case (r)
            0: pper[k] = 0;
            1: pper[k] = 1;
            2: pper[k] = 64;
            3: pper[k] = 200;
            4: pper[k] = 63;
            5: pper[k] = 2;
            default: pper[k] = int'($urandom_range(3, 12));
          endcase
          pend[k] = 1'b1; pdrum[k] = 1'($urandom_range(0, 1));
          set_req(k, pper[k], pdrum[k]);
        end
      end
      req_valid_i = pend;
      mute_i = ($urandom_range(0, 15) == 0);
      err_clr_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) min_hold_i = 16'($urandom_range(0, 8));
      #1;
      if (g < 0) begin
        win = 1'b1; e_busy = 1'b0; e_pluck = 1'b0;
      end else begin
        age = c - (g + p + 3);
        win = (age >= 0) && (age >= int'(min_hold_i));
        e_busy = (c >= g + 1) && (c <= g + p + 2);
        e_pluck = (c == g + 1);
      end
      w = -1;
      if (win && !mute_i)
        for (int i = 0; i < 4; i++) if (w < 0 && pend[(ptr + i) % 4]) w = (ptr + i) % 4;
      e_ready = (w >= 0) ? 4'(1 << w) : 4'b0;
      n_checks++; if (req_ready_o !== e_ready) begin n_errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready_o, e_ready); end
      n_checks++; if (pluck_o !== e_pluck) begin n_errors++; $display("FAIL rnd_pluck c%0d: got %0h want %0h", c, pluck_o, e_pluck); end
      n_checks++; if (busy_o !== e_busy) begin n_errors++; $display("FAIL rnd_busy c%0d: got %0h want %0h", c, busy_o, e_busy); end
      n_checks++; if (period_o !== e_period) begin n_errors++; $display("FAIL rnd_period c%0d: got %0d want %0d", c, period_o, e_period); end
      n_checks++; if (drum_string_no !== e_drum) begin n_errors++; $display("FAIL rnd_drum c%0d: got %0h want %0h", c, drum_string_no, e_drum); end
      n_checks++; if (active_id_o !== e_active) begin n_errors++; $display("FAIL rnd_active c%0d: got %0d want %0d", c, active_id_o, e_active); end
      n_checks++; if (err_period_o !== e_err) begin n_errors++; $display("FAIL rnd_err c%0d: got %0h want %0h", c, err_period_o, e_err); end
      n_checks++; if (freeze_o !== e_freeze) begin n_errors++; $display("FAIL rnd_freeze c%0d: got %0h want %0h", c, freeze_o, e_freeze); end
      e_freeze = mute_i;
      legal = 1'b1;
      if (w >= 0) begin
        ptr = (w + 1) % 4;
        pend[w] = 1'b0;
        legal = (pper[w] >= 2) && (pper[w] <= 63);
        if (legal) begin
          g = c; p = pper[w]; e_period = 8'(pper[w]); e_drum = pdrum[w]; e_active = 2'(w);
        end
      end
      if (w >= 0 && !legal) e_err = 1'b1;
      else if (err_clr_i) e_err = 1'b0;
    end
    mute_i = 1'b0; err_clr_i = 1'b0; req_valid_i = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single_pluck();
    test_round_robin();
    test_illegal_period();
    test_min_hold();
    test_mute();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
